// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command sequencer driving an external 4-bit ALU
// Purpose: accepts one register-file command at a time, issues ALU operands,
//   captures the ALU return into R0..R3 and {C,Z,V}, and emits a response pulse.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm   command fields
//   alu_a, alu_b, alu_opcode           registered operands to the external ALU
//   alu_result, alu_carry, alu_zero, alu_overflow   ALU return
//   rsp_valid, rsp_result, rsp_flags, rsp_err      response ({C,Z,V} flags)
//   trap, trap_clr                     overflow trap status and clear
// Option: define ALU_SEQ_OVF_TRAP_EN to stall in TRAP after an ADD/SUB overflow.
module alu_op_sequencer #(
  parameter logic [3:0] REG_RST_VAL = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_flags,
  output logic       rsp_err,
  output logic       trap,
  input  logic       trap_clr
);

`ifdef ALU_SEQ_OVF_TRAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_CAPTURE = 2'd2, S_TRAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_CAPTURE = 2'd2} state_t;
`endif

  localparam logic [3:0] OP_LDI = 4'b1000;

  state_t     r_state;
  logic [3:0] r_regs [0:3];
  logic [2:0] r_flags;
  logic [3:0] r_op;
  logic [1:0] r_rd;
  logic [1:0] r_rs1;
  logic [1:0] r_rs2;
  logic [3:0] r_imm;
  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [3:0] r_alu_opcode;
  logic       r_rsp_valid;
  logic [3:0] r_rsp_result;
  logic [2:0] r_rsp_flags;
  logic       r_rsp_err;
  logic       r_cmd_ready;

`ifdef ALU_SEQ_OVF_TRAP_EN
  logic r_trap;
  logic w_add_sub;
  // Only ADD and SUB can raise the trap; logical ops report V from the ALU as-is.
  assign w_add_sub = (r_op[3:1] == 3'b000);
  assign trap      = r_trap;
`else
  logic w_unused_trap_clr;
  assign w_unused_trap_clr = trap_clr;
  assign trap              = 1'b0;
`endif

  assign cmd_ready  = r_cmd_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_opcode;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < 4; i++) r_regs[i] <= REG_RST_VAL;
      r_flags      <= 3'b000;
      r_op         <= 4'b0000;
      r_rd         <= 2'b00;
      r_rs1        <= 2'b00;
      r_rs2        <= 2'b00;
      r_imm        <= 4'b0000;
      r_alu_a      <= 4'b0000;
      r_alu_b      <= 4'b0000;
      r_alu_opcode <= 4'b0000;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 4'b0000;
      r_rsp_flags  <= 3'b000;
      r_rsp_err    <= 1'b0;
      r_cmd_ready  <= 1'b0;
`ifdef ALU_SEQ_OVF_TRAP_EN
      r_trap       <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // cmd_ready is registered, so it rises one edge after reset release.
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= cmd_op;
            r_rd        <= cmd_rd;
            r_rs1       <= cmd_rs1;
            r_rs2       <= cmd_rs2;
            r_imm       <= cmd_imm;
            r_cmd_ready <= 1'b0;
            r_state     <= S_ISSUE;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          // Operands are read here, before the CAPTURE writeback, so rd==rs is safe.
          if (!r_op[3]) begin
            r_alu_a      <= r_regs[r_rs1];
            r_alu_b      <= r_regs[r_rs2];
            r_alu_opcode <= r_op;
          end
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_rsp_valid <= 1'b1;
          if (!r_op[3]) begin
            r_regs[r_rd] <= alu_result;
            r_flags      <= {alu_carry, alu_zero, alu_overflow};
            r_rsp_result <= alu_result;
            r_rsp_flags  <= {alu_carry, alu_zero, alu_overflow};
            r_rsp_err    <= 1'b0;
          end else if (r_op == OP_LDI) begin
            r_regs[r_rd] <= r_imm;
            r_flags      <= {1'b0, (r_imm == 4'b0000), 1'b0};
            r_rsp_result <= r_imm;
            r_rsp_flags  <= {1'b0, (r_imm == 4'b0000), 1'b0};
            r_rsp_err    <= 1'b0;
          end else begin
            r_rsp_result <= 4'b0000;
            r_rsp_flags  <= r_flags;
            r_rsp_err    <= 1'b1;
          end
`ifdef ALU_SEQ_OVF_TRAP_EN
          if (w_add_sub && alu_overflow) begin
            r_trap  <= 1'b1;
            r_state <= S_TRAP;
          end else begin
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
`else
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
`endif
        end
`ifdef ALU_SEQ_OVF_TRAP_EN
        S_TRAP: begin
          if (trap_clr) begin
            r_trap      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
`endif
        default: begin
          r_cmd_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs1;
  logic [1:0] cmd_rs2;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_opcode;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       alu_overflow;
  logic       rsp_valid;
  logic [3:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       rsp_err;
  logic       trap;
  logic       trap_clr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: register file, flags and the last operands sent to the ALU.
  logic [3:0] m_regs [4];
  logic [2:0] m_flags;
  logic [3:0] m_alu_a;
  logic [3:0] m_alu_b;
  logic [3:0] m_alu_op;

  // Scoreboard entries are {result, flags, err}.
  logic [7:0] sb_q [$];

  logic [3:0] obs_result;
  logic [2:0] obs_flags;
  logic       obs_err;

  always #5 clk = ~clk;

  // External ALU: returns {result, carry, zero, overflow}. SUB carry is a borrow.
  function automatic logic [6:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] res;
    logic       c;
    logic       v;
    s = 5'd0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        s   = {1'b0, a} + {1'b0, b};
        res = s[3:0];
        c   = s[4];
        v   = (a[3] == b[3]) && (res[3] != a[3]);
      end
      4'd1: begin
        res = a - b;
        c   = (a < b);
        v   = (a[3] != b[3]) && (res[3] != a[3]);
      end
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = a;
      4'd6:    res = ~a;
      4'd7:    res = b;
      default: res = 4'd0;
    endcase
    return {res, c, (res == 4'd0), v};
  endfunction

  assign {alu_result, alu_carry, alu_zero, alu_overflow} = alu_f(alu_opcode, alu_a, alu_b);

  alu_op_sequencer #(.REG_RST_VAL(4'b0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rd       (cmd_rd),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_imm      (cmd_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err),
    .trap         (trap),
    .trap_clr     (trap_clr)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_flags  = 3'b000;
    m_alu_a  = 4'd0;
    m_alu_b  = 4'd0;
    m_alu_op = 4'd0;
  endtask

  // Applies one command to the reference state and pushes its expected response.
  task automatic model_push(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic [3:0] imm, output logic exp_trap);
    logic [6:0] r;
    exp_trap = 1'b0;
    if (!op[3]) begin
      r        = alu_f(op, m_regs[rs1], m_regs[rs2]);
      m_alu_a  = m_regs[rs1];
      m_alu_b  = m_regs[rs2];
      m_alu_op = op;
      m_regs[rd] = r[6:3];
      m_flags  = r[2:0];
      sb_q.push_back({r[6:3], r[2:0], 1'b0});
      exp_trap = (op == 4'd0 || op == 4'd1) && r[0];
    end else if (op == 4'b1000) begin
      m_regs[rd] = imm;
      m_flags  = {1'b0, (imm == 4'd0), 1'b0};
      sb_q.push_back({imm, m_flags, 1'b0});
    end else begin
      sb_q.push_back({4'd0, m_flags, 1'b1});
    end
  endtask

  task automatic drive_fields(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                              input logic [1:0] rs2, input logic [3:0] imm);
    cmd_op  = op;
    cmd_rd  = rd;
    cmd_rs1 = rs1;
    cmd_rs2 = rs2;
    cmd_imm = imm;
  endtask

  // One complete command: handshake, latency, response, ALU hold and trap behaviour.
  task automatic send_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [3:0] imm);
    logic       exp_trap;
    logic [7:0] exp;
    int         budget;
    model_push(op, rd, rs1, rs2, imm, exp_trap);
    @(negedge clk);
    cmd_valid = 1'b1;
    drive_fields(op, rd, rs1, rs2, imm);
    budget = 0;
    while (cmd_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_timeout op=%b cmd_ready=%b required 1", op, cmd_ready);
      cmd_valid = 1'b0;
      void'(sb_q.pop_front());
    end else begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      n_checks++;
      if ({cmd_ready, rsp_valid} !== 2'b00) begin
        n_errors++;
        $display("FAIL issue_phase op=%b cmd_ready,rsp_valid=%b required 00", op, {cmd_ready, rsp_valid});
      end
      @(negedge clk);
      n_checks++;
      if ({cmd_ready, rsp_valid} !== 2'b00) begin
        n_errors++;
        $display("FAIL capture_phase op=%b cmd_ready,rsp_valid=%b required 00", op, {cmd_ready, rsp_valid});
      end
      @(negedge clk);
      exp = sb_q.pop_front();
      obs_result = rsp_result;
      obs_flags  = rsp_flags;
      obs_err    = rsp_err;
      n_checks++;
      if (rsp_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL rsp_latency op=%b rsp_valid=%b required 1", op, rsp_valid);
      end
      n_checks++;
      if ({rsp_result, rsp_flags, rsp_err} !== exp) begin
        n_errors++;
        $display("FAIL rsp_data op=%b got res=%b flags=%b err=%b required res=%b flags=%b err=%b",
                 op, rsp_result, rsp_flags, rsp_err, exp[7:4], exp[3:1], exp[0]);
      end
      n_checks++;
      if ({alu_a, alu_b, alu_opcode} !== {m_alu_a, m_alu_b, m_alu_op}) begin
        n_errors++;
        $display("FAIL alu_outputs op=%b got a=%b b=%b opc=%b required a=%b b=%b opc=%b",
                 op, alu_a, alu_b, alu_opcode, m_alu_a, m_alu_b, m_alu_op);
      end
`ifdef ALU_SEQ_OVF_TRAP_EN
      n_checks++;
      if ({trap, cmd_ready} !== (exp_trap ? 2'b10 : 2'b01)) begin
        n_errors++;
        $display("FAIL trap_entry op=%b trap,cmd_ready=%b required %b", op, {trap, cmd_ready},
                 (exp_trap ? 2'b10 : 2'b01));
      end
`else
      n_checks++;
      if ({trap, cmd_ready} !== 2'b01) begin
        n_errors++;
        $display("FAIL ready_after_rsp op=%b trap,cmd_ready=%b required 01", op, {trap, cmd_ready});
      end
`endif
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rsp_pulse op=%b rsp_valid=%b required 0", op, rsp_valid);
      end
      if (exp_trap) begin
`ifdef ALU_SEQ_OVF_TRAP_EN
        repeat (2) @(negedge clk);
        n_checks++;
        if ({trap, cmd_ready} !== 2'b10) begin
          n_errors++;
          $display("FAIL trap_hold trap,cmd_ready=%b required 10", {trap, cmd_ready});
        end
`endif
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
        n_checks++;
        if ({trap, cmd_ready} !== 2'b01) begin
          n_errors++;
          $display("FAIL trap_clear trap,cmd_ready=%b required 01", {trap, cmd_ready});
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    trap_clr  = 1'b0;
    drive_fields(4'd0, 2'd0, 2'd0, 2'd0, 4'd0);
    model_reset();
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_err, trap, alu_a, alu_b, alu_opcode} !== 23'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got %b required all zero",
               {cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_err, trap, alu_a, alu_b, alu_opcode});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_before_edge cmd_ready=%b required 0", cmd_ready);
    end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_first_edge cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_ldi_add();
    send_cmd(4'b1000, 2'd0, 2'd0, 2'd0, 4'd7);
    send_cmd(4'b1000, 2'd1, 2'd0, 2'd0, 4'd9);
    send_cmd(4'b0000, 2'd2, 2'd0, 2'd1, 4'd0);
    n_checks++;
    if ({obs_result, obs_flags} !== {4'b0000, 3'b110}) begin
      n_errors++;
      $display("FAIL add_wrap got res=%b flags=%b required res=0000 flags=110", obs_result, obs_flags);
    end
    send_cmd(4'd5, 2'd2, 2'd2, 2'd2, 4'd0);
    n_checks++;
    if (obs_result !== 4'b0000) begin
      n_errors++;
      $display("FAIL r2_readback got %b required 0000", obs_result);
    end
  endtask

  task automatic test_sub();
    send_cmd(4'b1000, 2'd0, 2'd0, 2'd0, 4'd3);
    send_cmd(4'b1000, 2'd1, 2'd0, 2'd0, 4'd5);
    send_cmd(4'b0001, 2'd3, 2'd0, 2'd1, 4'd0);
    n_checks++;
    if ({obs_result, obs_flags} !== {4'b1110, 3'b100}) begin
      n_errors++;
      $display("FAIL sub_borrow got res=%b flags=%b required res=1110 flags=100", obs_result, obs_flags);
    end
  endtask

  task automatic test_overflow();
    send_cmd(4'b1000, 2'd0, 2'd0, 2'd0, 4'd5);
    send_cmd(4'b1000, 2'd1, 2'd0, 2'd0, 4'd4);
    send_cmd(4'b0000, 2'd2, 2'd0, 2'd1, 4'd0);
    n_checks++;
    if ({obs_result, obs_flags} !== {4'b1001, 3'b001}) begin
      n_errors++;
      $display("FAIL add_overflow got res=%b flags=%b required res=1001 flags=001", obs_result, obs_flags);
    end
  endtask

  task automatic test_illegal();
    send_cmd(4'b1010, 2'd1, 2'd2, 2'd3, 4'd15);
    n_checks++;
    if ({obs_result, obs_flags, obs_err} !== {4'b0000, 3'b001, 1'b1}) begin
      n_errors++;
      $display("FAIL illegal_rsp got res=%b flags=%b err=%b required res=0000 flags=001 err=1",
               obs_result, obs_flags, obs_err);
    end
    send_cmd(4'b1111, 2'd0, 2'd0, 2'd0, 4'd0);
    n_checks++;
    if (obs_flags !== 3'b001) begin
      n_errors++;
      $display("FAIL illegal_flags_kept got %b required 001", obs_flags);
    end
    for (int k = 0; k < 4; k++) send_cmd(4'd5, k[1:0], k[1:0], k[1:0], 4'd0);
  endtask

  task automatic test_rd_eq_rs();
    send_cmd(4'b1000, 2'd0, 2'd0, 2'd0, 4'd2);
    send_cmd(4'b0000, 2'd0, 2'd0, 2'd0, 4'd0);
    n_checks++;
    if ({obs_result, obs_flags} !== {4'b0100, 3'b000}) begin
      n_errors++;
      $display("FAIL rd_eq_rs got res=%b flags=%b required res=0100 flags=000", obs_result, obs_flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] b_op  [4];
    logic [1:0] b_rd  [4];
    logic [1:0] b_rs1 [4];
    logic [1:0] b_rs2 [4];
    logic [3:0] b_imm [4];
    logic       dummy_trap;
    logic       will;
    logic [7:0] exp;
    int         idx;
    int         rsps;
    int         phase;
    int         last_acc;
    b_op[0] = 4'b1000; b_rd[0] = 2'd0; b_rs1[0] = 2'd0; b_rs2[0] = 2'd0; b_imm[0] = 4'd2;
    b_op[1] = 4'b1000; b_rd[1] = 2'd1; b_rs1[1] = 2'd0; b_rs2[1] = 2'd0; b_imm[1] = 4'd3;
    b_op[2] = 4'b0000; b_rd[2] = 2'd2; b_rs1[2] = 2'd0; b_rs2[2] = 2'd1; b_imm[2] = 4'd0;
    b_op[3] = 4'b0100; b_rd[3] = 2'd3; b_rs1[3] = 2'd1; b_rs2[3] = 2'd2; b_imm[3] = 4'd0;
    idx = 0;
    rsps = 0;
    phase = 0;
    last_acc = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    drive_fields(b_op[0], b_rd[0], b_rs1[0], b_rs2[0], b_imm[0]);
    model_push(b_op[0], b_rd[0], b_rs1[0], b_rs2[0], b_imm[0], dummy_trap);
    for (int cyc = 0; cyc < 40 && rsps < 4; cyc++) begin
      will = cmd_valid && (cmd_ready === 1'b1);
      @(negedge clk);
      if (will) begin
        phase = 1;
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc != 3) begin
            n_errors++;
            $display("FAIL b2b_spacing got %0d cycles required 3", cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
        if (idx < 4) begin
          drive_fields(b_op[idx], b_rd[idx], b_rs1[idx], b_rs2[idx], b_imm[idx]);
          model_push(b_op[idx], b_rd[idx], b_rs1[idx], b_rs2[idx], b_imm[idx], dummy_trap);
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        phase++;
      end
      if (phase == 1 || phase == 2) begin
        n_checks++;
        if (cmd_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL b2b_ready_low phase=%0d cmd_ready=%b required 0", phase, cmd_ready);
        end
      end
      if (rsp_valid === 1'b1) begin
        rsps++;
        exp = sb_q.pop_front();
        n_checks++;
        if (phase != 3 || {rsp_result, rsp_flags, rsp_err} !== exp) begin
          n_errors++;
          $display("FAIL b2b_rsp phase=%0d got res=%b flags=%b err=%b required phase 3 res=%b flags=%b err=%b",
                   phase, rsp_result, rsp_flags, rsp_err, exp[7:4], exp[3:1], exp[0]);
        end
      end
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (rsps != 4) begin
      n_errors++;
      $display("FAIL b2b_count got %0d responses required 4", rsps);
      sb_q.delete();
    end
  endtask

  task automatic test_reset_midflight();
    int budget;
    int spurious;
    @(negedge clk);
    cmd_valid = 1'b1;
    drive_fields(4'b0000, 2'd0, 2'd1, 2'd2, 4'd0);
    budget = 0;
    while (cmd_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_err, trap, alu_a, alu_b, alu_opcode} !== 23'd0) begin
      n_errors++;
      $display("FAIL midflight_reset_outputs got %b required all zero",
               {cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_err, trap, alu_a, alu_b, alu_opcode});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious != 0) begin
      n_errors++;
      $display("FAIL midflight_no_rsp got %0d rsp_valid cycles required 0", spurious);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midflight_ready cmd_ready=%b required 1", cmd_ready);
    end
    for (int k = 0; k < 4; k++) begin
      send_cmd(4'd5, k[1:0], k[1:0], k[1:0], 4'd0);
      n_checks++;
      if (obs_result !== 4'b0000) begin
        n_errors++;
        $display("FAIL midflight_reg R%0d got %b required 0000", k, obs_result);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ldi_add();
    test_sub();
    test_overflow();
    test_illegal();
    test_rd_eq_rs();
    test_back_to_back();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
